// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared op codes, FSM states and default width for the bit-serial ALU
package alu_serial_pkg;
  localparam int DEF_W = 8;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10} state_e;
endpackage

// File: rtl/alu_serial_seq_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice; SUB inverts i1 so the caller supplies cin=1
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic i0,
  input  logic i1,
  input  logic cin,
  input  op_e  op,
  output logic y,
  output logic cout
);
  logic bx;
  always_comb begin
    bx   = (op == OP_SUB) ? ~i1 : i1;
    y    = (op == OP_AND) ? (i0 & i1) : (op == OP_XOR) ? (i0 ^ i1) : (i0 ^ bx ^ cin);
    cout = op[1] ? 1'b0 : ((i0 & bx) | (i0 & cin) | (bx & cin));
  end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: LSB-first bit-serial sequencer around one alu_bit_slice
// Optional zero/ovf flag logic enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int W = DEF_W,
  localparam int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         ovf
);
  state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] a_sr, b_sr, r_sr;
  op_e op_r;
  logic carry, s_y, s_cout, accept, last;
  logic [W-1:0] r_fin;
  alu_bit_slice u_slice (
    .i0(a_sr[0]), .i1(b_sr[0]), .cin(carry), .op(op_r), .y(s_y), .cout(s_cout)
  );
  always_comb begin
    accept   = start && (state != ST_RUN);
    last     = (state == ST_RUN) && (cnt == CNT_W'(W - 1));
    r_fin    = {s_y, r_sr[W-1:1]};
    state_nx = accept ? ST_RUN : last ? ST_DONE : (state == ST_RUN) ? ST_RUN : ST_IDLE;
  end
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      op_r   <= OP_ADD;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        op_r  <= op_e'(op);
        cnt   <= '0;
        carry <= op[0] & ~op[1];
      end else if (state == ST_RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= r_fin;
        carry <= s_cout;
        cnt   <= last ? cnt : cnt + CNT_W'(1);
      end
      if (last) begin
        result <= r_fin;
        cout   <= op_r[1] ? 1'b0 : s_cout;
      end
    end
  end
`ifdef ALU_SERIAL_FLAGS_EN
  // carry holds the carry into the MSB while the last bit is in the slice
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (last) begin
      zero <= (r_fin == '0);
      ovf  <= op_r[1] ? 1'b0 : (carry ^ s_cout);
    end
  end
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed self-checking bench for alu_serial_seq at W=8
module tb_alu_serial_seq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] a, b, result;
  logic [1:0] op;
  logic busy, done, cout, zero, ovf;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_serial_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .ovf(ovf)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic chk_flags(input string tag, input logic ez, input logic eo);
`ifdef ALU_SERIAL_FLAGS_EN
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, ovf}, 32'd0);
`endif
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] er, input logic ec,
                        input logic ez, input logic eo);
    int n;
    start = 1'b1; op = o; a = xa; b = xb;
    tick();
    start = 1'b0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({tag, ".latency"}, n, W);
    chk({tag, ".result"}, {24'd0, result}, {24'd0, er});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk_flags(tag, ez, eo);
    tick();
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".hold"}, {24'd0, result}, {24'd0, er});
  endtask
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 2'b00;
    tick();
    tick();
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", {24'd0, result}, 32'd0);
    chk("rst.cout", {31'd0, cout}, 32'd0);
    chk_flags("rst", 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    run_op("add1", 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1);
    run_op("add2", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub1", 2'b01, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0);
    run_op("sub2", 2'b01, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("and", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("xor", 2'b11, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0);
    // start pulsed mid-RUN with new operands must be ignored
    start = 1'b1; op = 2'b00; a = 8'h5A; b = 8'h3C;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op = 2'b01; a = 8'h11; b = 8'h22;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ign.latency", n, W - 3);
    chk("ign.result", {24'd0, result}, 32'h96);
    chk("ign.cout", {31'd0, cout}, 32'd0);
    // start held in DONE launches the next op immediately
    start = 1'b1; op = 2'b01; a = 8'h10; b = 8'h01;
    tick();
    start = 1'b0;
    chk("b2b.busy", {31'd0, busy}, 32'd1);
    chk("b2b.result_held", {24'd0, result}, 32'h96);
    wait_done(n);
    chk("b2b.latency", n, W);
    chk("b2b.result", {24'd0, result}, 32'h0F);
    chk("b2b.cout", {31'd0, cout}, 32'd1);
    tick();
    // reset during RUN discards the op
    start = 1'b1; op = 2'b00; a = 8'h5A; b = 8'h3C;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.done", {31'd0, done}, 32'd0);
    chk("mrst.result", {24'd0, result}, 32'd0);
    chk("mrst.cout", {31'd0, cout}, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n += int'(done) + int'(busy);
    end
    chk("mrst.quiet", n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
